coin_input_conditioner: RTL

- Front-end stage directly upstream of the vending-machine FSM.
- Takes raw, bouncy coin-slot sensors (nickel, dime, quarter) and the raw "Done" push-button, and delivers clean one-cycle events.
- Coin events carry the 2-bit coin code the FSM consumes (nickel 00, dime 01, quarter 10).
- Rejects ambiguous multi-coin detections and suppresses mechanical double counts.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/coin_input_conditioner_if.sv | 28 ++
 rtl/coin_input_conditioner_debounce_channel.sv | 43 ++++
 rtl/coin_input_conditioner.sv | 91 +++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes and small helpers used by the
// input conditioner, the vending FSM and the dispenser.
package vend_pkg;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NICKEL  = 2'b00;
  localparam coin_code_t COIN_DIME    = 2'b01;
  localparam coin_code_t COIN_QUARTER = 2'b10;
  localparam coin_code_t COIN_NONE    = 2'b11;

  localparam int NUM_COINS = 3;

  // Bit order of the event vector: [0]=nickel, [1]=dime, [2]=quarter.
  function automatic coin_code_t code_of(input logic [NUM_COINS-1:0] onehot);
    coin_code_t code;
    case (onehot)
      3'b001:  code = COIN_NICKEL;
      3'b010:  code = COIN_DIME;
      3'b100:  code = COIN_QUARTER;
      default: code = COIN_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] count_ones3(input logic [NUM_COINS-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Raw sensor inputs and conditioned event outputs of the coin front end.
interface coin_input_conditioner_if;
  import vend_pkg::*;

  logic       nickel_raw;
  logic       dime_raw;
  logic       quarter_raw;
  logic       done_raw;

  // coin_valid, done_pulse and coin_reject are single-cycle strobes with no
  // ready/backpressure: the consumer must sample them every clock.
  logic       coin_valid;
  coin_code_t coin_code;
  logic       done_pulse;
  logic       coin_reject;
  logic       lockout_active;

  modport master (
    output nickel_raw, dime_raw, quarter_raw, done_raw,
    input  coin_valid, coin_code, done_pulse, coin_reject, lockout_active
  );

  modport slave (
    input  nickel_raw, dime_raw, quarter_raw, done_raw,
    output coin_valid, coin_code, done_pulse, coin_reject, lockout_active
  );

endinterface

// File: rtl/coin_input_conditioner_debounce_channel.sv
// One raw input: 2-flop synchronizer, debounce counter and stable level.
// rise pulses for one cycle when the stable level goes 0->1.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        // Release is debounced the same way but only a rise is reported.
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: debounces the three coin sensors and the Done button,
// arbitrates coin events, applies post-coin lockout and orders Done after coins.
module coin_input_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  coin_input_conditioner_if.slave  bus
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [3:0]           raw;
  logic [3:0]           rise;
  logic [NUM_COINS-1:0] coin_ev;
  logic [1:0]           n_ev;
  logic                 accept;
  logic                 multi;
  logic                 done_req;
  logic                 done_pend;
  logic [LW-1:0]        lock_cnt;
  logic [LW-1:0]        lock_next;

  logic                 coin_valid_q;
  coin_code_t           coin_code_q;
  logic                 done_pulse_q;
  logic                 coin_reject_q;
  logic                 lockout_active_q;

  assign raw = {bus.done_raw, bus.quarter_raw, bus.dime_raw, bus.nickel_raw};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    coin_ev  = rise[NUM_COINS-1:0];
    n_ev     = count_ones3(coin_ev);
    // Multi-coin detections are rejected even inside lockout: the event is ambiguous.
    multi    = (n_ev >= 2'd2);
    accept   = (n_ev == 2'd1) && (lock_cnt == '0);
    done_req = rise[3] | done_pend;
    if (accept) begin
      lock_next = LW'(LOCKOUT_CYCLES);
    end else if (lock_cnt != '0) begin
      lock_next = lock_cnt - LW'(1);
    end else begin
      lock_next = lock_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_valid_q     <= 1'b0;
      coin_code_q      <= COIN_NONE;
      done_pulse_q     <= 1'b0;
      coin_reject_q    <= 1'b0;
      lockout_active_q <= 1'b0;
      done_pend        <= 1'b0;
      lock_cnt         <= '0;
    end else begin
      coin_valid_q     <= accept;
      coin_reject_q    <= multi;
      // A Done that collides with an accepted coin waits one cycle in done_pend.
      done_pulse_q     <= done_req & ~accept;
      done_pend        <= done_req & accept;
      lock_cnt         <= lock_next;
      lockout_active_q <= (lock_next != '0);
      if (accept) begin
        coin_code_q <= code_of(coin_ev);
      end
    end
  end

  assign bus.coin_valid     = coin_valid_q;
  assign bus.coin_code      = coin_code_q;
  assign bus.done_pulse     = done_pulse_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.lockout_active = lockout_active_q;

endmodule
